// File: rtl/line_burst_adaptor.sv
// Converts one cacheline read/write into a BEATS-long burst on a narrow memory bus.
// Optional protocol checker enabled by defining LINE_BURST_PROTO_CHK_EN (adds proto_err).
module line_burst_adaptor #(
   parameter int LINE_W  = 256,
   parameter int BURST_W = 64,
   parameter int ADDR_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pmem_read,
   input  logic              pmem_write,
   input  logic [ADDR_W-1:0] pmem_address,
   input  logic [LINE_W-1:0] pmem_wdata,
   output logic              pmem_resp,
   output logic [LINE_W-1:0] pmem_rdata,
   output logic [ADDR_W-1:0] address_o,
   output logic              read_o,
   output logic              write_o,
   output logic [BURST_W-1:0] burst_o,
   input  logic [BURST_W-1:0] burst_i,
`ifdef LINE_BURST_PROTO_CHK_EN
   output logic              proto_err,
`endif
   input  logic              resp_i
);

   localparam int BEATS = LINE_W / BURST_W;
   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int OFF_W = $clog2(LINE_W / 8);
   localparam logic [ADDR_W-1:0] ADDR_MASK = ~ADDR_W'((64'd1 << OFF_W) - 64'd1);
   localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);

   typedef enum logic [1:0] {
      IDLE,
      RD_BURST,
      WR_BURST,
      DONE
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [LINE_W-1:0]  line_q, line_d;
   logic [LINE_W-1:0]  rdata_q, rdata_d;

   // line_q holds the write line during a write and assembles beats during a read;
   // rdata_q only takes the line once a read burst has fully completed.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      line_d  = line_q;
      rdata_d = rdata_q;
      case (state_q)
         IDLE: begin
            if (pmem_write) begin
               line_d  = pmem_wdata;
               addr_d  = pmem_address & ADDR_MASK;
               state_d = WR_BURST;
            end else if (pmem_read) begin
               addr_d  = pmem_address & ADDR_MASK;
               state_d = RD_BURST;
            end
         end
         RD_BURST: begin
            if (resp_i) begin
               line_d[cnt_q*BURST_W +: BURST_W] = burst_i;
               if (cnt_q == LAST_BEAT) begin
                  cnt_d   = '0;
                  rdata_d = line_d;
                  state_d = DONE;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         WR_BURST: begin
            if (resp_i) begin
               if (cnt_q == LAST_BEAT) begin
                  cnt_d   = '0;
                  state_d = DONE;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         line_q  <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         line_q  <= line_d;
         rdata_q <= rdata_d;
      end
   end

   // Strobes decode straight from the state flop so reset clears them asynchronously.
   assign read_o     = (state_q == RD_BURST);
   assign write_o    = (state_q == WR_BURST);
   assign pmem_resp  = (state_q == DONE);
   assign pmem_rdata = rdata_q;
   assign address_o  = addr_q;
   assign burst_o    = (state_q == WR_BURST) ? line_q[cnt_q*BURST_W +: BURST_W] : '0;

`ifdef LINE_BURST_PROTO_CHK_EN
   logic proto_err_q, proto_err_d;

   // Sticky flag: stray beat handshakes outside a burst, or a request dropped mid-burst.
   always_comb begin
      proto_err_d = proto_err_q;
      if (resp_i && ((state_q == IDLE) || (state_q == DONE))) begin
         proto_err_d = 1'b1;
      end
      if ((state_q == RD_BURST) && !pmem_read) begin
         proto_err_d = 1'b1;
      end
      if ((state_q == WR_BURST) && !pmem_write) begin
         proto_err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         proto_err_q <= 1'b0;
      end else begin
         proto_err_q <= proto_err_d;
      end
   end

   assign proto_err = proto_err_q;
`endif

endmodule

// File: tb/tb_line_burst_adaptor.sv
// Self-checking bench for line_burst_adaptor: randomized beats and gaps against a
// transaction-level model of the line/beat mapping (LINE_BURST_PROTO_CHK_EN aware).
module tb_line_burst_adaptor;

   localparam int LINE_W  = 256;
   localparam int BURST_W = 64;
   localparam int ADDR_W  = 32;
   localparam int BEATS   = LINE_W / BURST_W;
   localparam int LINE_BYTES = LINE_W / 8;

   logic              clk;
   logic              rst;
   logic              pmem_read;
   logic              pmem_write;
   logic [ADDR_W-1:0] pmem_address;
   logic [LINE_W-1:0] pmem_wdata;
   logic              pmem_resp;
   logic [LINE_W-1:0] pmem_rdata;
   logic [ADDR_W-1:0] address_o;
   logic              read_o;
   logic              write_o;
   logic [BURST_W-1:0] burst_o;
   logic [BURST_W-1:0] burst_i;
   logic              resp_i;
`ifdef LINE_BURST_PROTO_CHK_EN
   logic              proto_err;
`endif

   int checks;
   int errors;
   logic [LINE_W-1:0]  last_rdata;
   logic [BURST_W-1:0] beats [BEATS];

   line_burst_adaptor #(
      .LINE_W (LINE_W),
      .BURST_W(BURST_W),
      .ADDR_W (ADDR_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .pmem_read   (pmem_read),
      .pmem_write  (pmem_write),
      .pmem_address(pmem_address),
      .pmem_wdata  (pmem_wdata),
      .pmem_resp   (pmem_resp),
      .pmem_rdata  (pmem_rdata),
      .address_o   (address_o),
      .read_o      (read_o),
      .write_o     (write_o),
      .burst_o     (burst_o),
      .burst_i     (burst_i),
`ifdef LINE_BURST_PROTO_CHK_EN
      .proto_err   (proto_err),
`endif
      .resp_i      (resp_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Line address: the byte address rounded down to a whole line.
   function automatic logic [ADDR_W-1:0] line_addr(input logic [ADDR_W-1:0] a);
      return a - (a % LINE_BYTES);
   endfunction

   // Handshake pattern: 0 = always ready, 1 = fixed 1,0,1,0,1,1 then ready, 2 = random.
   function automatic logic gap_resp(input int mode, input int k);
      logic [5:0] pat;
      pat = 6'b110101;
      if (mode == 0) return 1'b1;
      if (mode == 1) return (k < 6) ? pat[k] : 1'b1;
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic fill_beats(input int kind);
      for (int i = 0; i < BEATS; i++) begin
         if (kind == 0) beats[i] = {16{4'(i + 1)}};
         else beats[i] = {$urandom, $urandom};
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      #1;
      checks++;
      if ({read_o, write_o, pmem_resp} !== 3'b000 || address_o !== '0 || burst_o !== '0 || pmem_rdata !== '0) begin
         errors++;
         $display("[TB] FAIL reset_outputs: got rd=%b wr=%b resp=%b addr=%h burst=%h rdata=%h required all zero",
                  read_o, write_o, pmem_resp, address_o, burst_o, pmem_rdata);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({read_o, write_o, pmem_resp} !== 3'b000) begin
         errors++;
         $display("[TB] FAIL reset_idle: got rd=%b wr=%b resp=%b required 000", read_o, write_o, pmem_resp);
      end
      last_rdata = '0;
   endtask

   task automatic run_read(input logic [ADDR_W-1:0] addr, input int mode, input string name);
      int done_beats, cyc, slot;
      bit fin;
      logic [LINE_W-1:0] exp_line;
      for (int i = 0; i < BEATS; i++) exp_line[i*BURST_W +: BURST_W] = beats[i];
      pmem_read = 1'b1;
      pmem_address = addr;
      done_beats = 0; cyc = 0; slot = 0; fin = 0;
      while (!fin && cyc < 200) begin
         @(posedge clk);
         if (resp_i) done_beats++;
         @(negedge clk);
         cyc++;
         if (done_beats < BEATS) begin
            checks++;
            if (read_o !== 1'b1 || write_o !== 1'b0 || pmem_resp !== 1'b0 || address_o !== line_addr(addr)) begin
               errors++;
               $display("[TB] FAIL %s_burst: cyc %0d got rd=%b wr=%b resp=%b addr=%h required 1 0 0 %h",
                        name, cyc, read_o, write_o, pmem_resp, address_o, line_addr(addr));
            end
            resp_i = gap_resp(mode, slot);
            slot++;
            burst_i = resp_i ? beats[done_beats] : {$urandom, $urandom};
            if (mode == 2) pmem_address = $urandom;
         end else begin
            checks++;
            if (pmem_resp !== 1'b1 || read_o !== 1'b0 || pmem_rdata !== exp_line) begin
               errors++;
               $display("[TB] FAIL %s_done: got resp=%b rd=%b rdata=%h required 1 0 %h",
                        name, pmem_resp, read_o, pmem_rdata, exp_line);
            end
            if (mode == 0) begin
               checks++;
               if (cyc !== 5) begin
                  errors++;
                  $display("[TB] FAIL %s_latency: got %0d cycles required 5", name, cyc);
               end
            end
            fin = 1;
            pmem_read = 1'b0;
            resp_i = 1'b0;
         end
      end
      if (!fin) begin
         errors++;
         $display("[TB] FAIL %s_timeout: got no pmem_resp in %0d cycles required completion", name, cyc);
         pmem_read = 1'b0;
         resp_i = 1'b0;
      end
      last_rdata = exp_line;
      @(negedge clk);
      checks++;
      if (pmem_resp !== 1'b0 || pmem_rdata !== exp_line) begin
         errors++;
         $display("[TB] FAIL %s_after: got resp=%b rdata=%h required 0 %h", name, pmem_resp, pmem_rdata, exp_line);
      end
   endtask

   task automatic run_write(input logic [ADDR_W-1:0] addr, input logic [LINE_W-1:0] wline,
                            input int mode, input bit both, input string name);
      int done_beats, cyc, slot;
      bit fin;
      pmem_write = 1'b1;
      pmem_read = both;
      pmem_address = addr;
      pmem_wdata = wline;
      done_beats = 0; cyc = 0; slot = 0; fin = 0;
      while (!fin && cyc < 200) begin
         @(posedge clk);
         if (resp_i) done_beats++;
         @(negedge clk);
         cyc++;
         if (done_beats < BEATS) begin
            checks++;
            if (write_o !== 1'b1 || read_o !== 1'b0 || pmem_resp !== 1'b0 || address_o !== line_addr(addr) ||
                burst_o !== wline[done_beats*BURST_W +: BURST_W]) begin
               errors++;
               $display("[TB] FAIL %s_beat%0d: cyc %0d got wr=%b rd=%b resp=%b addr=%h data=%h required 1 0 0 %h %h",
                        name, done_beats, cyc, write_o, read_o, pmem_resp, address_o, burst_o,
                        line_addr(addr), wline[done_beats*BURST_W +: BURST_W]);
            end
            resp_i = gap_resp(mode, slot);
            slot++;
            if (mode == 2) begin
               pmem_address = $urandom;
               pmem_wdata = {8{$urandom}};
            end
         end else begin
            checks++;
            if (pmem_resp !== 1'b1 || write_o !== 1'b0 || read_o !== 1'b0 || pmem_rdata !== last_rdata) begin
               errors++;
               $display("[TB] FAIL %s_done: got resp=%b wr=%b rd=%b rdata=%h required 1 0 0 %h",
                        name, pmem_resp, write_o, read_o, pmem_rdata, last_rdata);
            end
            if (mode == 0) begin
               checks++;
               if (cyc !== 5) begin
                  errors++;
                  $display("[TB] FAIL %s_latency: got %0d cycles required 5", name, cyc);
               end
            end
            fin = 1;
            pmem_write = 1'b0;
            pmem_read = 1'b0;
            resp_i = 1'b0;
         end
      end
      if (!fin) begin
         errors++;
         $display("[TB] FAIL %s_timeout: got no pmem_resp in %0d cycles required completion", name, cyc);
         pmem_write = 1'b0;
         pmem_read = 1'b0;
         resp_i = 1'b0;
      end
      @(negedge clk);
      checks++;
      if (pmem_resp !== 1'b0 || write_o !== 1'b0) begin
         errors++;
         $display("[TB] FAIL %s_after: got resp=%b wr=%b required 0 0", name, pmem_resp, write_o);
      end
   endtask

   task automatic test_read_no_gaps;
      fill_beats(0);
      run_read(32'h0000_1234, 0, "read_nogap");
   endtask

   task automatic test_write_gaps;
      logic [LINE_W-1:0] wl;
      wl = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC, 64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
      run_write(32'h0000_4567, wl, 1, 1'b0, "write_gap");
      run_write(32'h0000_8000, {8{$urandom}}, 0, 1'b0, "write_nogap");
   endtask

   task automatic test_simultaneous;
      run_write(32'h0000_0ABC, {8{$urandom}}, 0, 1'b1, "simul");
   endtask

   task automatic test_reset_mid_burst;
      int taken;
      fill_beats(1);
      pmem_read = 1'b1;
      pmem_address = 32'h0000_0F00;
      taken = 0;
      @(posedge clk);
      for (int c = 0; c < 50 && taken < 2; c++) begin
         @(negedge clk);
         resp_i = 1'b1;
         burst_i = beats[taken];
         @(posedge clk);
         taken++;
      end
      @(negedge clk);
      rst = 1'b1;
      pmem_read = 1'b0;
      resp_i = 1'b0;
      #1;
      checks++;
      if (read_o !== 1'b0 || pmem_resp !== 1'b0 || pmem_rdata !== '0 || address_o !== '0) begin
         errors++;
         $display("[TB] FAIL reset_mid: got rd=%b resp=%b rdata=%h addr=%h required 0 0 0 0",
                  read_o, pmem_resp, pmem_rdata, address_o);
      end
      @(negedge clk);
      rst = 1'b0;
      last_rdata = '0;
      @(negedge clk);
      fill_beats(1);
      run_read(32'h0000_0F08, 0, "read_after_rst");
   endtask

   task automatic test_back_to_back;
      fill_beats(1);
      run_read(32'h0000_0100, 0, "b2b_read");
      run_write(32'h0000_0200, {8{$urandom}}, 0, 1'b0, "b2b_write");
      checks++;
      if (pmem_rdata !== last_rdata) begin
         errors++;
         $display("[TB] FAIL b2b_rdata_kept: got %h required %h", pmem_rdata, last_rdata);
      end
   endtask

   task automatic test_random;
      for (int n = 0; n < 12; n++) begin
         if ($urandom_range(0, 1) == 1) begin
            fill_beats(1);
            run_read($urandom, 2, "rand_read");
         end else begin
            run_write($urandom, {8{$urandom}}, 2, 1'($urandom_range(0, 1)), "rand_write");
         end
      end
   endtask

`ifdef LINE_BURST_PROTO_CHK_EN
   task automatic test_proto;
      @(negedge clk);
      checks++;
      if (proto_err !== 1'b0) begin
         errors++;
         $display("[TB] FAIL proto_clean: got %b required 0", proto_err);
      end
      resp_i = 1'b1;
      @(negedge clk);
      resp_i = 1'b0;
      checks++;
      if (proto_err !== 1'b1) begin
         errors++;
         $display("[TB] FAIL proto_set: got %b required 1", proto_err);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (proto_err !== 1'b1) begin
         errors++;
         $display("[TB] FAIL proto_sticky: got %b required 1", proto_err);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (proto_err !== 1'b0) begin
         errors++;
         $display("[TB] FAIL proto_reset: got %b required 0", proto_err);
      end
      @(negedge clk);
      rst = 1'b0;
      last_rdata = '0;
   endtask
`endif

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      pmem_read = 1'b0;
      pmem_write = 1'b0;
      pmem_address = '0;
      pmem_wdata = '0;
      burst_i = '0;
      resp_i = 1'b0;
      last_rdata = '0;
      test_reset;
      test_read_no_gaps;
      test_write_gaps;
      test_simultaneous;
      test_reset_mid_burst;
      test_back_to_back;
      test_random;
`ifdef LINE_BURST_PROTO_CHK_EN
      test_proto;
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/line_burst_adaptor.md
Name: line_burst_adaptor

Overview:
- Responder for the 256-bit cacheline physical-memory interface (pmem_*) driven by the L2 cache.
- Accepts one line read or line write at a time and converts it into a BEATS-long burst on a narrow 64-bit memory bus.
- On a read, reassembles the beats into a line. Sits between the L2 cache and the main-memory model/controller.

Parameters:
- LINE_W, 256, line width in bits; must be a multiple of BURST_W.
- BURST_W, 64, burst beat width in bits.
- ADDR_W, 32, address width.
- BEATS (derived, not overridable), LINE_W/BURST_W = 4, beats per line.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- pmem_read  input  1  line read request; held high until pmem_resp.
- pmem_write  input  1  line write request; held high until pmem_resp.
- pmem_address  input  ADDR_W  line address.
- pmem_wdata  input  LINE_W  write line.
- pmem_resp  output  1  one-cycle completion pulse.
- pmem_rdata  output  LINE_W  read line; valid when pmem_resp=1.
- address_o  output  ADDR_W  burst address, line-aligned.
- read_o  output  1  burst read request.
- write_o  output  1  burst write request.
- burst_o  output  BURST_W  write beat data.
- burst_i  input  BURST_W  read beat data.
- resp_i  input  1  beat handshake; one beat transferred per cycle it is high.

Behaviour:
- States: IDLE, RD_BURST, WR_BURST, DONE. A beat counter cnt of width clog2(BEATS) tracks progress.
- Reset (async, any state, including mid-burst): state=IDLE, cnt=0, pmem_resp=0, read_o=0, write_o=0, address_o=0, burst_o=0, pmem_rdata=0. Any partial burst is abandoned.
- IDLE with pmem_write=1:
  - Latch pmem_wdata and address into internal registers.
  - Go to WR_BURST.
  - Write has priority when pmem_read and pmem_write are high together; the read is not served and the cache is expected to keep its request up.
- IDLE with pmem_read=1 (and pmem_write=0): latch the address and go to RD_BURST.
- Address latching: address_o = pmem_address with low clog2(LINE_W/8)=5 bits forced to 0. It is stable for the whole burst.
- RD_BURST:
  - read_o=1.
  - Each cycle resp_i=1: store burst_i into line slice [cnt*BURST_W +: BURST_W], then cnt++.
  - On the beat where cnt==BEATS-1: cnt wraps to 0, read_o drops next cycle, go to DONE.
- WR_BURST:
  - write_o=1 and burst_o = latched line slice cnt, so beat 0 is driven in the first WR_BURST cycle.
  - Each cycle resp_i=1, cnt++ and burst_o advances to the next slice on the following cycle.
  - After the last beat: cnt=0, go to DONE.
- resp_i gaps: the counter holds and outputs hold.
- DONE:
  - pmem_resp=1 for exactly one cycle.
  - pmem_rdata is the assembled line. It is updated only by completed read bursts and stays stable otherwise.
  - Go to IDLE.
- A request still high in the cycle after DONE is treated as a new request. The cache must drop it on pmem_resp.
- Latency with resp_i continuously high:
  - Request seen in IDLE at cycle 0.
  - read_o/write_o high cycles 1..4.
  - pmem_resp at cycle 5.
  - Minimum back-to-back spacing is 6 cycles.
- Input sampling: pmem_* inputs are sampled only in IDLE. Changes during a burst are ignored.
- resp_i outside RD_BURST/WR_BURST is ignored (see optional feature).

Optional Feature:
- Macro: LINE_BURST_PROTO_CHK_EN.
- When defined:
  - Adds output proto_err (1 bit, reset 0).
  - proto_err is set and sticky until rst if resp_i=1 while state is IDLE or DONE, or if pmem_read/pmem_write deasserts while in RD_BURST/WR_BURST.
  - Functional behaviour is otherwise identical.
- When undefined: the port and its logic are absent.

Test Plan:
- Read, no gaps:
  - Stimulus: pmem_read=1, pmem_address=0x0000_1234; memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 with resp_i held high.
  - Required: address_o=0x0000_1220; pmem_resp pulses at cycle 5; pmem_rdata = {0x44..44, 0x33..33, 0x22..22, 0x11..11}.
- Write with gaps:
  - Stimulus: pmem_write=1, pmem_wdata = {D,C,B,A} (64-bit words); resp_i toggles 1,0,1,0,1,1.
  - Required: burst_o sequence A,B,C,D, each held through the gaps; write_o drops after the fourth beat; single pmem_resp pulse.
- Simultaneous request:
  - Stimulus: pmem_read=1 and pmem_write=1 in the same cycle.
  - Required: a write burst is issued and read_o stays 0 throughout.
- Reset mid-burst:
  - Stimulus: assert rst after 2 read beats; then deassert and issue a new read.
  - Required: read_o/pmem_resp fall immediately and asynchronously; the new read restarts at beat 0 and returns the correct line.
- Back-to-back:
  - Stimulus: a read to 0x100 then a write to 0x200.
  - Required: the second burst starts the cycle after the IDLE sample; pmem_rdata from the first read is unchanged after the write.
- LINE_BURST_PROTO_CHK_EN:
  - Stimulus: resp_i=1 while IDLE.
  - Required: proto_err=1 next cycle and it remains 1 until rst.
